// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO push arbiter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 16;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rtl/fifo_push_arbiter_rr_pick.sv - combinational round-robin picker, searching upward from ptr+1
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  int cand;

  // Wrap is explicit so non-power-of-two N never aliases onto unused indices.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand[W-1:0]]) begin
        found = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin, packet-locking arbiter for a shared FIFO push port
// Optional per-requester beat counters enabled by FIFO_PUSH_ARBITER_STATS_EN.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  output logic [N_REQ-1:0]            req_grant_o,
  output logic                        push_valid_o,
  output logic [DATA_WIDTH-1:0]       push_data_o,
  input  logic                        push_grant_i,
  output logic [$clog2(N_REQ)-1:0]    owner_o,
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  input  logic                        stats_clr_i,
  output logic [N_REQ*STAT_WIDTH-1:0] beat_cnt_o,
`endif
  output logic                        busy_o
);

  localparam int OWNER_WIDTH = $clog2(N_REQ);

  arb_state_t             state;
  logic [OWNER_WIDTH-1:0] owner;
  logic [OWNER_WIDTH-1:0] rr_ptr;
  logic [OWNER_WIDTH-1:0] pick_idx;
  logic [OWNER_WIDTH-1:0] sel;
  logic                   pick_found;
  logic                   sel_vld;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   xfer;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel       = (state == LOCKED) ? owner : pick_idx;
    sel_vld   = (state == LOCKED) | pick_found;
    sel_valid = sel_vld & req_valid_i[sel];
    sel_last  = req_last_i[sel];
    xfer      = sel_valid & push_grant_i;
  end

  // Outputs are forced low while reset is asserted, even if requesters still drive valid.
  always_comb begin
    push_valid_o = 1'b0;
    push_data_o  = '0;
    req_grant_o  = '0;
    owner_o      = owner;
    busy_o       = 1'b0;
    if (reset_n) begin
      push_valid_o = sel_valid;
      busy_o       = (state == LOCKED);
      if (sel_vld) begin
        push_data_o      = req_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        owner_o          = sel;
        req_grant_o[sel] = xfer;
      end
    end
  end

  // owner also tracks the last IDLE pick so owner_o holds it when nothing is selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= OWNER_WIDTH'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            if (xfer && sel_last) rr_ptr <= pick_idx;
            else                  state  <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && sel_last) begin
            state  <= IDLE;
            rr_ptr <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic [N_REQ-1:0][STAT_WIDTH-1:0] beat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (stats_clr_i)
          beat_cnt[k] <= '0;
        else if (req_grant_o[k] && beat_cnt[k] != STAT_MAX)
          beat_cnt[k] <= beat_cnt[k] + 1'b1;
      end
    end
  end

  assign beat_cnt_o = beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - directed self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int DW    = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]  req_last;
  logic [N_REQ-1:0]  req_grant;
  logic              push_valid;
  logic [DW-1:0]     push_data;
  logic              push_grant;
  logic [1:0]        owner;
  logic              busy;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic                        stats_clr;
  logic [N_REQ*STAT_WIDTH-1:0] beat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fifo_push_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_grant_o  (req_grant),
    .push_valid_o (push_valid),
    .push_data_o  (push_data),
    .push_grant_i (push_grant),
    .owner_o      (owner),
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    .stats_clr_i  (stats_clr),
    .beat_cnt_o   (beat_cnt),
`endif
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_data;
    reset_n    = 1'b0;
    req_valid  = 4'b1111;
    req_last   = 4'b1111;
    req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    push_grant = 1'b1;
`ifdef FIFO_PUSH_ARBITER_STATS_EN
    stats_clr  = 1'b0;
`endif
    #1;
    repeat (2) tick;
    check("rst_grant", 32'(req_grant), 32'h0);
    check("rst_valid", 32'(push_valid), 32'h0);
    check("rst_data",  32'(push_data), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);

    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_data = 8'hA0 + 8'(i % 4);
      check("rr_grant", 32'(req_grant), 32'(4'b0001 << (i % 4)));
      check("rr_data",  32'(push_data), 32'(exp_data));
      tick;
    end

    // single beat from req 1 moves the pointer so req 2 is next in line
    req_valid = 4'b0010;
    #1 check("pre_grant", 32'(req_grant), 32'h2);
    tick;
    req_valid = 4'b1110;
    req_last  = 4'b1011;
    req_data[16 +: 8] = 8'h21;
    #1;
    check("lock_g1", 32'(req_grant), 32'h4);
    check("lock_b1", 32'(busy), 32'h0);
    check("lock_d1", 32'(push_data), 32'h21);
    tick;
    req_data[16 +: 8] = 8'h22;
    #1;
    check("lock_g2", 32'(req_grant), 32'h4);
    check("lock_b2", 32'(busy), 32'h1);
    check("lock_d2", 32'(push_data), 32'h22);
    tick;
    req_last = 4'b1111;
    req_data[16 +: 8] = 8'h23;
    #1;
    check("lock_g3", 32'(req_grant), 32'h4);
    check("lock_b3", 32'(busy), 32'h1);
    tick;
    req_data[16 +: 8] = 8'hA2;
    #1;
    check("lock_next", 32'(req_grant), 32'h8);
    check("lock_idle", 32'(busy), 32'h0);
    tick;

    req_valid  = 4'b0010;
    push_grant = 1'b0;
    #1;
    check("bp_grant0", 32'(req_grant), 32'h0);
    check("bp_valid",  32'(push_valid), 32'h1);
    check("bp_owner0", 32'(owner), 32'h1);
    tick;
    req_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_owner", 32'(owner), 32'h1);
      check("bp_busy",  32'(busy), 32'h1);
      check("bp_grant", 32'(req_grant), 32'h0);
      check("bp_data",  32'(push_data), 32'hA1);
      tick;
    end
    push_grant = 1'b1;
    #1 check("bp_release", 32'(req_grant), 32'h2);
    tick;
    req_valid = 4'b0001;
    #1;
    check("bp_after", 32'(req_grant), 32'h1);
    check("bp_idle",  32'(busy), 32'h0);
    tick;

    req_valid = 4'b1100;
    req_last  = 4'b1011;
    #1 check("gap_g1", 32'(req_grant), 32'h4);
    tick;
    req_valid = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("gap_valid", 32'(push_valid), 32'h0);
      check("gap_grant", 32'(req_grant), 32'h0);
      check("gap_busy",  32'(busy), 32'h1);
      check("gap_owner", 32'(owner), 32'h2);
      tick;
    end
    req_valid = 4'b1100;
    #1 check("gap_g2", 32'(req_grant), 32'h4);
    tick;
    req_last = 4'b1111;
    #1;
    check("gap_g3", 32'(req_grant), 32'h4);
    check("gap_b3", 32'(busy), 32'h1);
    tick;
    #1 check("gap_next", 32'(req_grant), 32'h8);
    tick;

    req_valid = 4'b0100;
    req_last  = 4'b1011;
    #1 check("ar_g1", 32'(req_grant), 32'h4);
    tick;
    req_valid = 4'b0111;
    #1 check("ar_lock", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("ar_grant", 32'(req_grant), 32'h0);
    check("ar_valid", 32'(push_valid), 32'h0);
    check("ar_busy",  32'(busy), 32'h0);
    check("ar_owner", 32'(owner), 32'h0);
    check("ar_data",  32'(push_data), 32'h0);
    tick;
    #2;
    reset_n  = 1'b1;
    req_last = 4'b1111;
    #1 check("ar_first", 32'(req_grant), 32'h1);
    tick;

`ifdef FIFO_PUSH_ARBITER_STATS_EN
    req_valid = 4'b0001;
    repeat (70000) tick;
    check("st_sat", 32'(beat_cnt[15:0]), 32'hFFFF);
    stats_clr = 1'b1;
    #1 check("st_clr_beat", 32'(req_grant), 32'h1);
    tick;
    stats_clr = 1'b0;
    req_valid = 4'b0000;
    #1 check("st_clr", 32'(beat_cnt[15:0]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
